// File: rtl/mem_block_initiator.sv
// mem_block_initiator: initiator side of the 64-bit block port into main_memory.
// Takes one block request at a time (READ, WRITE, WB_FILL, reserved), runs the
// write phase, a one-cycle gap and/or the read phase with MEM_LATENCY-cycle
// holds, then pulses exactly one response.
// Optional build macro MEM_INITIATOR_STATS_EN adds saturating stat_reads and
// stat_writes phase counters.
module mem_block_initiator #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [9:0]  req_addr,
  input  logic [9:0]  req_wb_addr,
  input  logic [63:0] req_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [63:0] rsp_data,
  output logic        mem_write,
  output logic [9:0]  mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
`ifdef MEM_INITIATOR_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes
`endif
);

  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DONE} state_t;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_WB_FILL = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;
  localparam logic [3:0] LAT_M1     = 4'(MEM_LATENCY - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [1:0]  op_reg, op_next;
  logic [6:0]  addr_reg, addr_next;          // read block index, kept for WB_FILL
  logic [9:0]  mem_address_reg, mem_address_next;
  logic [63:0] mem_write_data_reg, mem_write_data_next;
  logic        mem_write_reg;
  logic [63:0] rsp_data_reg;
  logic        capture;
  logic        read_done;
  logic        write_done;

  // Only the block index of the addresses matters; the byte offset is dropped.
  logic unused_offset;
  assign unused_offset = ^{req_addr[2:0], req_wb_addr[2:0]};

  // Next-state, phase counter and memory-port values for the next cycle.
  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_reg;
    op_next             = op_reg;
    addr_next           = addr_reg;
    mem_address_next    = mem_address_reg;
    mem_write_data_next = mem_write_data_reg;
    capture             = 1'b0;
    read_done           = 1'b0;
    write_done          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          op_next   = req_op;
          addr_next = req_addr[9:3];
          case (req_op)
            OP_READ: begin
              state_next       = READ;
              cnt_next         = LAT_M1;
              mem_address_next = {req_addr[9:3], 3'b000};
            end
            OP_WRITE: begin
              state_next          = WRITE;
              cnt_next            = LAT_M1;
              mem_address_next    = {req_addr[9:3], 3'b000};
              mem_write_data_next = req_data;
            end
            OP_WB_FILL: begin
              state_next          = WRITE;
              cnt_next            = LAT_M1;
              mem_address_next    = {req_wb_addr[9:3], 3'b000};
              mem_write_data_next = req_data;
            end
            default: state_next = DONE;   // reserved op: error response, no memory access
          endcase
        end
      end
      WRITE: begin
        if (cnt_reg == 4'd0) begin
          state_next = GAP;
          write_done = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      GAP: begin
        // Strobe is already low here, so the read address never overlaps a write.
        if (op_reg == OP_WB_FILL) begin
          state_next       = READ;
          cnt_next         = LAT_M1;
          mem_address_next = {addr_reg, 3'b000};
        end else begin
          state_next = DONE;
        end
      end
      READ: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
          capture    = 1'b1;
          read_done  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, request fields and registered memory-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      cnt_reg            <= 4'd0;
      op_reg             <= 2'b00;
      addr_reg           <= 7'd0;
      mem_address_reg    <= 10'd0;
      mem_write_data_reg <= 64'd0;
      mem_write_reg      <= 1'b0;
      rsp_data_reg       <= 64'd0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      op_reg             <= op_next;
      addr_reg           <= addr_next;
      mem_address_reg    <= mem_address_next;
      mem_write_data_reg <= mem_write_data_next;
      mem_write_reg      <= (state_next == WRITE);
      if (capture) rsp_data_reg <= mem_read_data;
    end
  end

  assign req_ready      = (state_reg == IDLE);
  assign rsp_valid      = (state_reg == DONE);
  assign rsp_err        = (state_reg == DONE) && (op_reg == OP_RSVD);
  assign rsp_data       = rsp_data_reg;
  assign mem_write      = mem_write_reg;
  assign mem_address    = mem_address_reg;
  assign mem_write_data = mem_write_data_reg;

`ifdef MEM_INITIATOR_STATS_EN
  logic [15:0] stat_reads_reg;
  logic [15:0] stat_writes_reg;

  // Saturating counts of completed read and write phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_reg  <= 16'd0;
      stat_writes_reg <= 16'd0;
    end else begin
      if (read_done && stat_reads_reg != 16'hFFFF) stat_reads_reg <= stat_reads_reg + 16'd1;
      if (write_done && stat_writes_reg != 16'hFFFF) stat_writes_reg <= stat_writes_reg + 16'd1;
    end
  end

  assign stat_reads  = stat_reads_reg;
  assign stat_writes = stat_writes_reg;
`else
  logic unused_done;
  assign unused_done = read_done ^ write_done;
`endif

endmodule

// File: tb/tb_mem_block_initiator.sv
// Testbench for mem_block_initiator: directed cases followed by random requests.
// A driver pushes the expected response of each accepted request into a
// scoreboard queue; a negedge monitor pops and compares every response.
module tb_mem_block_initiator;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [9:0]  req_addr;
  logic [9:0]  req_wb_addr;
  logic [63:0] req_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_data;
  logic        mem_write;
  logic [9:0]  mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;
`ifdef MEM_INITIATOR_STATS_EN
  logic [15:0] stat_reads;
  logic [15:0] stat_writes;
`endif

  mem_block_initiator #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wb_addr(req_wb_addr),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
`ifdef MEM_INITIATOR_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Power-up content of every memory block.
  function automatic logic [63:0] init_word(input int idx);
    if (idx == 3) return 64'hDEADBEEF_01234567;
    return {32'h600D_0000 + 32'(idx) * 32'h0000_9E37, 32'hF00F_0000 ^ 32'(idx)};
  endfunction

  // main_memory stand-in driven by the DUT's port.
  logic [63:0] bench_mem [128];
  bit          bench_wr  [128];
  always @(posedge clk) begin
    if (mem_write) begin
      bench_mem[mem_address[9:3]] <= mem_write_data;
      bench_wr[mem_address[9:3]]  <= 1'b1;
    end
  end
  assign mem_read_data = bench_wr[mem_address[9:3]] ? bench_mem[mem_address[9:3]]
                                                    : init_word(int'(mem_address[9:3]));

  // Reference memory and counters, maintained by the driver.
  logic [63:0] model_mem [128];
  bit          model_wr  [128];
  logic [63:0] last_rd = 64'd0;
  int          m_reads = 0;
  int          m_writes = 0;

  function automatic logic [63:0] model_read(input int idx);
    return model_wr[idx] ? model_mem[idx] : init_word(idx);
  endfunction

  typedef struct {
    logic [1:0]  op;
    int          exp_cyc;
    logic        err;
    logic [63:0] data;
    logic [9:0]  wr_addr;
    logic [9:0]  rd_addr;
    logic [63:0] wdata;
    int          wcycles;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit rst_chk = 1'b0;
  bit fin_chk = 1'b0;
  int wcnt = 0;
  int ntxn = 0;
  exp_t e;

  // Monitor: reset checks, per-cycle handshake/strobe checks, response scoreboard.
  always @(negedge clk) begin
    if (rst_chk) begin
      wcnt = 0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_write !== 1'b0 ||
          mem_address !== 10'd0 || mem_write_data !== 64'd0 || rsp_data !== 64'd0) begin
        errors++;
        $display("FAIL reset_values: ready=%b rsp_valid=%b rsp_err=%b mem_write=%b addr=%h wdata=%h rsp_data=%h, required 1 0 0 0 000 0 0",
                 req_ready, rsp_valid, rsp_err, mem_write, mem_address, mem_write_data, rsp_data);
      end
`ifdef MEM_INITIATOR_STATS_EN
      checks++;
      if (stat_reads !== 16'd0 || stat_writes !== 16'd0) begin
        errors++;
        $display("FAIL reset_stats: reads=%0d writes=%0d, required 0 0", stat_reads, stat_writes);
      end
`endif
    end else if (fin_chk) begin
      for (int i = 0; i < 128; i++) begin
        checks++;
        if ((bench_wr[i] ? bench_mem[i] : init_word(i)) !== model_read(i)) begin
          errors++;
          $display("FAIL memory_block_%0d: got %h, required %h", i,
                   bench_wr[i] ? bench_mem[i] : init_word(i), model_read(i));
        end
      end
`ifdef MEM_INITIATOR_STATS_EN
      checks++;
      if (stat_reads !== 16'(m_reads) || stat_writes !== 16'(m_writes)) begin
        errors++;
        $display("FAIL stats: reads=%0d writes=%0d, required %0d %0d", stat_reads, stat_writes, m_reads, m_writes);
      end
`endif
    end else if (mon_en && !rst) begin
      checks++;
      if (req_ready !== (sb.size() == 0)) begin
        errors++;
        $display("FAIL req_ready: got %b, required %b at cycle %0d", req_ready, sb.size() == 0, cyc);
      end
      if (mem_write) begin
        wcnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stray_write: mem_write=1 with no request at cycle %0d, required 0", cyc);
        end else if (mem_address !== sb[0].wr_addr || mem_write_data !== sb[0].wdata) begin
          errors++;
          $display("FAIL write_port: addr=%h data=%h, required addr=%h data=%h", mem_address,
                   mem_write_data, sb[0].wr_addr, sb[0].wdata);
        end
      end
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb.pop_front();
          ntxn++;
          $display("txn %0d op=%0d rsp_err=%0b rsp_data=%h cycle=%0d", ntxn, e.op, rsp_err, rsp_data, cyc);
          if (cyc != e.exp_cyc) begin
            errors++;
            $display("FAIL rsp_timing: response at cycle %0d, required %0d", cyc, e.exp_cyc);
          end
          checks++;
          if (rsp_err !== e.err || rsp_data !== e.data) begin
            errors++;
            $display("FAIL rsp_content: err=%b data=%h, required err=%b data=%h", rsp_err, rsp_data, e.err, e.data);
          end
          checks++;
          if (wcnt != e.wcycles) begin
            errors++;
            $display("FAIL write_strobe_len: %0d cycles, required %0d", wcnt, e.wcycles);
          end
          if (e.op != 2'b11) begin
            checks++;
            if (mem_address !== ((e.op == 2'b01) ? e.wr_addr : e.rd_addr)) begin
              errors++;
              $display("FAIL final_address: got %h, required %h", mem_address,
                       (e.op == 2'b01) ? e.wr_addr : e.rd_addr);
            end
          end
          wcnt = 0;
        end
      end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout: no response by cycle %0d, required at %0d", cyc, sb[0].exp_cyc);
        void'(sb.pop_front());
        wcnt = 0;
      end
    end
  end

  // Drive one request, wait for acceptance, and push the model's expectation.
  task automatic issue(input logic [1:0] op, input logic [9:0] addr, input logic [9:0] wb,
                       input logic [63:0] data, input int gap);
    exp_t x;
    int   bound;
    int   acc;
    int   lat;
    @(negedge clk);
    if (gap > 0) begin
      req_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wb_addr = wb; req_data = data;
    bound = 0;
    while (!req_ready && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (!req_ready) begin
      $display("FAIL accept_timeout: req_ready=0 after 200 cycles, required 1");
      $fatal(1, "request never accepted");
    end
    acc = cyc + 1;
    x.op = op; x.err = (op == 2'b11); x.wdata = data;
    x.wr_addr = {(op == 2'b10) ? wb[9:3] : addr[9:3], 3'b000};
    x.rd_addr = {addr[9:3], 3'b000};
    x.wcycles = (op == 2'b01 || op == 2'b10) ? L : 0;
    case (op)
      2'b00: lat = L + 1;
      2'b01: lat = L + 2;
      2'b10: lat = 2 * L + 2;
      default: lat = 1;
    endcase
    if (op == 2'b01 || op == 2'b10) begin
      model_mem[x.wr_addr[9:3]] = data;
      model_wr[x.wr_addr[9:3]]  = 1'b1;
      m_writes++;
    end
    if (op == 2'b00 || op == 2'b10) begin
      last_rd = model_read(int'(addr[9:3]));
      m_reads++;
    end
    x.data = last_rd;
    x.exp_cyc = acc + lat - 1;
    @(posedge clk);
    sb.push_back(x);
    #1;
    // Scramble fields while busy; the DUT must use the registered copies.
    req_op = 2'($urandom); req_addr = 10'($urandom); req_wb_addr = 10'($urandom);
    req_data = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wb_addr = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_chk = 1'b1;
    @(posedge clk);
    rst_chk = 1'b0;
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases from the test plan.
    issue(2'b00, 10'h01F, 10'h000, 64'h0, 1);
    issue(2'b01, 10'h3FF, 10'h000, 64'hA5A5A5A5_5A5A5A5A, 1);
    issue(2'b10, 10'h080, 10'h040, 64'h1111_2222_3333_4444, 1);
    issue(2'b11, 10'h155, 10'h2AA, 64'h0, 1);
    issue(2'b00, 10'h040, 10'h000, 64'h0, 0);

    // Reset held two cycles in the middle of a write; the request is dropped.
    issue(2'b01, 10'h155, 10'h000, 64'hCAFE_F00D_0BAD_BEEF, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    sb.delete();
    last_rd = 64'd0; m_reads = 0; m_writes = 0;
    rst_chk = 1'b1;
    @(posedge clk);
    rst_chk = 1'b0;
    #1 req_valid = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;

    // Random requests; gap 0 keeps req_valid high across responses.
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), 10'($urandom), 10'($urandom), {$urandom, $urandom},
            int'($urandom_range(0, 2)));
    end
    req_valid = 1'b0;

    b = 0;
    while (sb.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    repeat (3) @(posedge clk);
    #1 fin_chk = 1'b1;
    @(posedge clk);
    fin_chk = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_block_initiator.md
# mem_block_initiator

- Initiator side of the 64-bit block port into `main_memory`.
- Accepts block requests (refill, write-back, write-back-then-refill) from the cache over a valid/ready handshake.
- Sequences `mem_write`, `mem_address` and `mem_write_data` with fixed hold times, captures `mem_read_data`, and returns one response per request.
- Sits between the cache controller and `main_memory`; it is the only driver of the memory port.

## Interface
- `MEM_LATENCY`, 2: cycles each memory phase holds address/data stable; legal range 1–15.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high exactly when state is IDLE.
- `req_op`  in  2  00 READ, 01 WRITE, 10 WB_FILL, 11 reserved.
- `req_addr`  in  10  byte address of the block to read, or to write for WRITE.
- `req_wb_addr`  in  10  victim byte address; used only by WB_FILL.
- `req_data`  in  64  write-back block data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_err`  out  1  qualifies `rsp_valid`; set for op 11.
- `rsp_data`  out  64  captured read block; holds its value until the next capture.
- `mem_write`  out  1  memory write strobe.
- `mem_address`  out  10  memory address; bits [2:0] always 0.
- `mem_write_data`  out  64  memory write data.
- `mem_read_data`  in  64  memory read data.

## Operation
- **States:** IDLE, WRITE, GAP, READ, DONE.
- **Accept:** a request is accepted on a rising edge with `req_valid && req_ready`. All request fields are registered at acceptance; later input changes are ignored.
- **IDLE → next state on accept:**
  - READ → READ.
  - WRITE → WRITE.
  - WB_FILL → WRITE, using `req_wb_addr`.
  - op 11 → DONE with `rsp_err` = 1; no memory activity.
- **WRITE:**
  - `mem_write` = 1, `mem_address` = {addr[9:3], 3'b000}, `mem_write_data` = registered data.
  - Lasts MEM_LATENCY cycles, then → GAP.
- **GAP:**
  - One cycle; `mem_write` = 0, address and data unchanged.
  - This guarantees the strobe falls before any new address is presented.
  - Plain WRITE → DONE. WB_FILL → READ.
- **READ:**
  - `mem_write` = 0, `mem_address` = {req_addr[9:3], 3'b000}.
  - Lasts MEM_LATENCY cycles. On the last cycle's edge, `mem_read_data` is captured into `rsp_data`. Then → DONE.
- **DONE:**
  - `rsp_valid` = 1 for exactly one cycle; `rsp_err` is 1 only for op 11.
  - Then → IDLE.
- **Phase counter:** 4-bit down-counter, loaded with MEM_LATENCY−1 on phase entry; the phase ends when the counter is 0.
- **No back-to-back accept:** `req_ready` is 0 in DONE, so the earliest next accept is the cycle after DONE.

## Timing
- **Reset values** (all outputs, after the first edge with `rst` = 1):
  - `req_ready` = 1 (state IDLE).
  - `rsp_valid`, `rsp_err`, `mem_write` = 0.
  - `mem_address`, `mem_write_data`, `rsp_data` = 0.
  - Counter = 0.
- **Reset mid-operation:** the operation is abandoned and no response is issued. `mem_write` drops to 0 on the reset edge.
- **Response cycle:** with accept at edge E0, `rsp_valid` is high in the cycle after:
  - READ: edge E0+L+1.
  - WRITE: edge E0+L+2.
  - WB_FILL: edge E0+2L+2.
  - op 11: edge E0+1.
- **Stable outputs:** `mem_address` and `mem_write_data` are registered, glitch-free, and change only at phase entry.
- **Simultaneous `rst` and `req_valid`:** reset wins; the request is not accepted.

## Configuration
- **`MEM_INITIATOR_STATS_EN`:** when defined, adds two outputs:
  - `stat_reads` (16): increments on each completed READ phase.
  - `stat_writes` (16): increments on each completed WRITE phase.
  - Both saturate at 0xFFFF, clear on `rst`, and op 11 counts neither.
- When not defined, the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-WRITE → `mem_write` = 0 on the next edge, `req_ready` = 1, no `rsp_valid`; all listed outputs are 0.
- **READ (L=2):** READ at `req_addr`=0x01F with `mem_read_data`=0xDEADBEEF_01234567 → `mem_address`=0x018 for 2 cycles, `mem_write`=0, `rsp_valid` at E0+3 with `rsp_data`=0xDEADBEEF_01234567.
- **WRITE (L=2):** WRITE at `req_addr`=0x3FF with data 0xA5A5A5A5_5A5A5A5A → `mem_address`=0x3F8, `mem_write`=1 for exactly 2 cycles, then 0 for the GAP cycle, `rsp_valid` at E0+4.
- **WB_FILL (L=2):** `req_wb_addr`=0x040, `req_addr`=0x080 → write phase at 0x040, GAP, read phase at 0x080, `rsp_valid` at E0+6; `mem_write` is never 1 while `mem_address`=0x080.
- **Reserved op and handshake:** `req_op`=11 → `rsp_valid`=1 with `rsp_err`=1 at E0+1 and no `mem_write` activity. `req_valid` held high continuously → one accept per response, `req_ready`=0 from accept through DONE.
- **Stats (macro on):** after 3 READs, 2 WRITEs and 1 WB_FILL → `stat_reads`=4, `stat_writes`=3.
